ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline register sitting directly downstream of the execute-stage ALU in the MIPS32 pipelined core.
- Captures the ALU result, store data and memory/writeback controls, and resolves conditional moves (MOVN/MOVZ via BZero) and overflow write suppression.
- Pre-computes address-alignment exceptions, inserts bubbles on EX stalls (including ALU_Stall from the divider) and honours M-stage stall/flush.

Parameters:
- BUBBLE_ZERO_DATA, 1, when 1 a bubble also clears the data fields (result, store data, PC); when 0 the data fields hold their previous value.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- EX_Stall  in  1  EX stage stalled (any cause)
- EX_Flush  in  1  EX stage squashed
- ALU_Stall  in  1  divider-busy stall from ALU
- M_Stall  in  1  MEM stage stalled
- M_Flush  in  1  MEM stage squashed (exception)
- EX_ALUResult  in  32  ALU Result
- EX_BZero  in  1  ALU BZero
- EX_EXC_Ov  in  1  ALU overflow
- EX_ReadData2  in  32  forwarded rt (store data)
- EX_RtRd  in  5  destination register
- EX_RegWrite, EX_Movn, EX_Movz, EX_MemRead, EX_MemWrite, EX_MemByte, EX_MemHalf, EX_MemSignExtend, EX_MemtoReg  in  1 each  decoded controls
- EX_RestartPC  in  32  restart PC for exceptions
- EX_IsBDS  in  1  instruction is in a branch delay slot
- M_ALUResult  out  32  registered result / memory address
- M_StoreData  out  32  registered store data
- M_RtRd  out  5  destination register
- M_RegWrite, M_MemRead, M_MemWrite, M_MemByte, M_MemHalf, M_MemSignExtend, M_MemtoReg  out  1 each  registered controls
- M_RestartPC  out  32  registered restart PC
- M_IsBDS  out  1  registered delay-slot flag
- M_EXC_Ov, M_EXC_AdEL, M_EXC_AdES  out  1 each  registered exceptions
- M_Valid  out  1  MEM stage holds a real instruction

Behaviour:
- All outputs are registered, updated on the posedge of clock only.
- Update priority per cycle:
  1. reset
  2. M_Flush
  3. M_Stall
  4. bubble, when EX_Stall | EX_Flush | ALU_Stall
  5. capture
- Reset: every output is 0, including M_Valid.
- M_Flush, regardless of M_Stall:
  - M_Valid, M_RegWrite, M_MemRead and M_MemWrite go to 0.
  - M_EXC_* go to 0.
  - Data fields follow the bubble rule below.
- M_Stall (no flush): all outputs hold.
- Bubble:
  - M_Valid=0; all control bits and M_EXC_* are 0.
  - Data fields are 0 if BUBBLE_ZERO_DATA, else held.
- Capture:
  - M_Valid=1.
  - Data and control fields copy their EX_* inputs.
- Writeback gating on capture:
  - M_RegWrite = EX_RegWrite & ~EX_EXC_Ov & ~(EX_Movn & EX_BZero) & ~(EX_Movz & ~EX_BZero).
  - EX_Movn and EX_Movz both high is illegal; the result is don't-care but M_RegWrite must not be X.
- Exceptions on capture:
  - M_EXC_Ov = EX_EXC_Ov.
  - Misaligned is true if any of:
    - word access (~MemByte & ~MemHalf) with ALUResult[1:0]≠0;
    - half access with ALUResult[0]=1.
  - M_EXC_AdEL = EX_MemRead & misaligned.
  - M_EXC_AdES = EX_MemWrite & misaligned.
  - On any EXC_AdE*, M_MemRead and M_MemWrite are forced to 0 in the same register, so no memory side effect occurs.
  - Byte accesses never fault.
- Latency: exactly 1 cycle from capture to output; there is no combinational path from inputs to outputs.
- Simultaneous events:
  - EX_Flush with M_Stall: the stage holds; no bubble is inserted.
  - ALU_Stall with EX_Flush: a bubble is inserted.
- Reset asserted mid-stall: all outputs are 0 on the next edge.
- Data widths are fixed at 32; no arithmetic is performed beyond the alignment checks.

Test Plan:
- Reset, then capture ADD with EX_ALUResult=0x0000_0010, RegWrite=1, RtRd=5 → next cycle M_ALUResult=0x10, M_RegWrite=1, M_RtRd=5, M_Valid=1.
- MOVN with BZero=1 → M_RegWrite=0. MOVZ with BZero=1 → M_RegWrite=1. ADD with EX_EXC_Ov=1 → M_RegWrite=0, M_EXC_Ov=1.
- LW with ALUResult=0x1002 → M_EXC_AdEL=1, M_MemRead=0. SH with 0x1001 → M_EXC_AdES=1, M_MemWrite=0. SB with 0x1003 → no exception, M_MemWrite=1.
- Hold ALU_Stall=1 for 3 cycles with SW inputs presented → M_Valid=0 and M_MemWrite=0 for 3 cycles; capture on the first cycle with ALU_Stall=0.
- Capture SW, then raise M_Stall for 2 cycles while changing EX inputs → outputs unchanged. Then assert M_Flush together with M_Stall → M_Valid=0, M_MemWrite=0.
- Assert reset for 1 cycle while M_Stall=1 with valid contents → all outputs 0 on the next edge.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the MIPS32 core. It registers the ALU result and
// controls, resolves MOVN/MOVZ and overflow write suppression, and flags misaligned accesses.
module ex_mem_stage #(
    parameter bit BUBBLE_ZERO_DATA = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        EX_Stall,
    input  logic        EX_Flush,
    input  logic        ALU_Stall,
    input  logic        M_Stall,
    input  logic        M_Flush,
    input  logic [31:0] EX_ALUResult,
    input  logic        EX_BZero,
    input  logic        EX_EXC_Ov,
    input  logic [31:0] EX_ReadData2,
    input  logic [4:0]  EX_RtRd,
    input  logic        EX_RegWrite,
    input  logic        EX_Movn,
    input  logic        EX_Movz,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic        EX_MemByte,
    input  logic        EX_MemHalf,
    input  logic        EX_MemSignExtend,
    input  logic        EX_MemtoReg,
    input  logic [31:0] EX_RestartPC,
    input  logic        EX_IsBDS,
    output logic [31:0] M_ALUResult,
    output logic [31:0] M_StoreData,
    output logic [4:0]  M_RtRd,
    output logic        M_RegWrite,
    output logic        M_MemRead,
    output logic        M_MemWrite,
    output logic        M_MemByte,
    output logic        M_MemHalf,
    output logic        M_MemSignExtend,
    output logic        M_MemtoReg,
    output logic [31:0] M_RestartPC,
    output logic        M_IsBDS,
    output logic        M_EXC_Ov,
    output logic        M_EXC_AdEL,
    output logic        M_EXC_AdES,
    output logic        M_Valid
);

    logic [31:0] r_alu_result;
    logic [31:0] r_store_data;
    logic [4:0]  r_rt_rd;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_mem_byte;
    logic        r_mem_half;
    logic        r_mem_sign_extend;
    logic        r_mem_to_reg;
    logic [31:0] r_restart_pc;
    logic        r_is_bds;
    logic        r_exc_ov;
    logic        r_exc_adel;
    logic        r_exc_ades;
    logic        r_valid;

    logic w_bubble;
    logic w_word_access;
    logic w_half_access;
    logic w_misaligned;
    logic w_adel;
    logic w_ades;
    logic w_addr_exc;
    logic w_reg_write;

    assign w_bubble      = EX_Stall | EX_Flush | ALU_Stall;
    assign w_word_access = ~EX_MemByte & ~EX_MemHalf;
    assign w_half_access = ~EX_MemByte & EX_MemHalf;
    assign w_misaligned  = (w_word_access & (EX_ALUResult[1:0] != 2'b00))
                         | (w_half_access & EX_ALUResult[0]);
    assign w_adel        = EX_MemRead & w_misaligned;
    assign w_ades        = EX_MemWrite & w_misaligned;
    assign w_addr_exc    = w_adel | w_ades;

    // MOVN writes only when rt != 0, MOVZ only when rt == 0; an overflowing op never writes.
    assign w_reg_write = EX_RegWrite & ~EX_EXC_Ov
                       & ~(EX_Movn & EX_BZero)
                       & ~(EX_Movz & ~EX_BZero);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_alu_result      <= 32'd0;
            r_store_data      <= 32'd0;
            r_rt_rd           <= 5'd0;
            r_reg_write       <= 1'b0;
            r_mem_read        <= 1'b0;
            r_mem_write       <= 1'b0;
            r_mem_byte        <= 1'b0;
            r_mem_half        <= 1'b0;
            r_mem_sign_extend <= 1'b0;
            r_mem_to_reg      <= 1'b0;
            r_restart_pc      <= 32'd0;
            r_is_bds          <= 1'b0;
            r_exc_ov          <= 1'b0;
            r_exc_adel        <= 1'b0;
            r_exc_ades        <= 1'b0;
            r_valid           <= 1'b0;
        end else if (M_Flush || (!M_Stall && w_bubble)) begin
            // A flush kills the M-stage instruction even while M is stalled.
            r_reg_write       <= 1'b0;
            r_mem_read        <= 1'b0;
            r_mem_write       <= 1'b0;
            r_mem_byte        <= 1'b0;
            r_mem_half        <= 1'b0;
            r_mem_sign_extend <= 1'b0;
            r_mem_to_reg      <= 1'b0;
            r_is_bds          <= 1'b0;
            r_exc_ov          <= 1'b0;
            r_exc_adel        <= 1'b0;
            r_exc_ades        <= 1'b0;
            r_valid           <= 1'b0;
            if (BUBBLE_ZERO_DATA) begin
                r_alu_result <= 32'd0;
                r_store_data <= 32'd0;
                r_rt_rd      <= 5'd0;
                r_restart_pc <= 32'd0;
            end
        end else if (!M_Stall) begin
            r_alu_result      <= EX_ALUResult;
            r_store_data      <= EX_ReadData2;
            r_rt_rd           <= EX_RtRd;
            r_reg_write       <= w_reg_write;
            // A faulting access must never reach the data memory.
            r_mem_read        <= EX_MemRead & ~w_addr_exc;
            r_mem_write       <= EX_MemWrite & ~w_addr_exc;
            r_mem_byte        <= EX_MemByte;
            r_mem_half        <= EX_MemHalf;
            r_mem_sign_extend <= EX_MemSignExtend;
            r_mem_to_reg      <= EX_MemtoReg;
            r_restart_pc      <= EX_RestartPC;
            r_is_bds          <= EX_IsBDS;
            r_exc_ov          <= EX_EXC_Ov;
            r_exc_adel        <= w_adel;
            r_exc_ades        <= w_ades;
            r_valid           <= 1'b1;
        end
    end

    assign M_ALUResult     = r_alu_result;
    assign M_StoreData     = r_store_data;
    assign M_RtRd          = r_rt_rd;
    assign M_RegWrite      = r_reg_write;
    assign M_MemRead       = r_mem_read;
    assign M_MemWrite      = r_mem_write;
    assign M_MemByte       = r_mem_byte;
    assign M_MemHalf       = r_mem_half;
    assign M_MemSignExtend = r_mem_sign_extend;
    assign M_MemtoReg      = r_mem_to_reg;
    assign M_RestartPC     = r_restart_pc;
    assign M_IsBDS         = r_is_bds;
    assign M_EXC_Ov        = r_exc_ov;
    assign M_EXC_AdEL      = r_exc_adel;
    assign M_EXC_AdES      = r_exc_ades;
    assign M_Valid         = r_valid;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: the driver issues one vector per clock and queues
// the hand-computed register contents; a negedge monitor pops and compares them.
module tb_ex_mem_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_stall, ex_flush, alu_stall, m_stall, m_flush;
  logic [31:0] ex_alu_result, ex_read_data2, ex_restart_pc;
  logic        ex_bzero, ex_exc_ov;
  logic [4:0]  ex_rt_rd;
  logic        ex_reg_write, ex_movn, ex_movz, ex_mem_read, ex_mem_write;
  logic        ex_mem_byte, ex_mem_half, ex_mem_sign_extend, ex_mem_to_reg, ex_is_bds;

  logic [31:0] m_alu_result, m_store_data, m_restart_pc;
  logic [4:0]  m_rt_rd;
  logic        m_reg_write, m_mem_read, m_mem_write, m_mem_byte, m_mem_half;
  logic        m_mem_sign_extend, m_mem_to_reg, m_is_bds;
  logic        m_exc_ov, m_exc_adel, m_exc_ades, m_valid;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        exc_ov;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rt_rd;
    logic [31:0] restart_pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  ex_mem_stage dut (
    .clock            (clock),
    .reset            (reset),
    .EX_Stall         (ex_stall),
    .EX_Flush         (ex_flush),
    .ALU_Stall        (alu_stall),
    .M_Stall          (m_stall),
    .M_Flush          (m_flush),
    .EX_ALUResult     (ex_alu_result),
    .EX_BZero         (ex_bzero),
    .EX_EXC_Ov        (ex_exc_ov),
    .EX_ReadData2     (ex_read_data2),
    .EX_RtRd          (ex_rt_rd),
    .EX_RegWrite      (ex_reg_write),
    .EX_Movn          (ex_movn),
    .EX_Movz          (ex_movz),
    .EX_MemRead       (ex_mem_read),
    .EX_MemWrite      (ex_mem_write),
    .EX_MemByte       (ex_mem_byte),
    .EX_MemHalf       (ex_mem_half),
    .EX_MemSignExtend (ex_mem_sign_extend),
    .EX_MemtoReg      (ex_mem_to_reg),
    .EX_RestartPC     (ex_restart_pc),
    .EX_IsBDS         (ex_is_bds),
    .M_ALUResult      (m_alu_result),
    .M_StoreData      (m_store_data),
    .M_RtRd           (m_rt_rd),
    .M_RegWrite       (m_reg_write),
    .M_MemRead        (m_mem_read),
    .M_MemWrite       (m_mem_write),
    .M_MemByte        (m_mem_byte),
    .M_MemHalf        (m_mem_half),
    .M_MemSignExtend  (m_mem_sign_extend),
    .M_MemtoReg       (m_mem_to_reg),
    .M_RestartPC      (m_restart_pc),
    .M_IsBDS          (m_is_bds),
    .M_EXC_Ov         (m_exc_ov),
    .M_EXC_AdEL       (m_exc_adel),
    .M_EXC_AdES       (m_exc_ades),
    .M_Valid          (m_valid)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, %0d entries still queued", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic set_ex(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                        input logic rw, input logic movn, input logic movz, input logic bz,
                        input logic ov, input logic mr, input logic mw, input logic mb,
                        input logic mh, input logic [31:0] pc);
    ex_alu_result      = alu;
    ex_read_data2      = sd;
    ex_rt_rd           = rd;
    ex_reg_write       = rw;
    ex_movn            = movn;
    ex_movz            = movz;
    ex_bzero           = bz;
    ex_exc_ov          = ov;
    ex_mem_read        = mr;
    ex_mem_write       = mw;
    ex_mem_byte        = mb;
    ex_mem_half        = mh;
    ex_mem_sign_extend = mr;
    ex_mem_to_reg      = mr;
    ex_restart_pc      = pc;
    ex_is_bds          = 1'b0;
  endtask

  // Queue what the registers must hold after the next edge, then take that edge.
  task automatic step(input logic v, input logic rw, input logic mr, input logic mw,
                      input logic ov, input logic adel, input logic ades,
                      input logic [31:0] alu, input logic [31:0] sd,
                      input logic [4:0] rd, input logic [31:0] pc);
    exp_t e;
    e.valid      = v;
    e.reg_write  = rw;
    e.mem_read   = mr;
    e.mem_write  = mw;
    e.exc_ov     = ov;
    e.exc_adel   = adel;
    e.exc_ades   = ades;
    e.alu_result = alu;
    e.store_data = sd;
    e.rt_rd      = rd;
    e.restart_pc = pc;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic step_zero();
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("M_Valid",     {31'd0, m_valid},     {31'd0, e.valid});
      chk("M_RegWrite",  {31'd0, m_reg_write}, {31'd0, e.reg_write});
      chk("M_MemRead",   {31'd0, m_mem_read},  {31'd0, e.mem_read});
      chk("M_MemWrite",  {31'd0, m_mem_write}, {31'd0, e.mem_write});
      chk("M_EXC_Ov",    {31'd0, m_exc_ov},    {31'd0, e.exc_ov});
      chk("M_EXC_AdEL",  {31'd0, m_exc_adel},  {31'd0, e.exc_adel});
      chk("M_EXC_AdES",  {31'd0, m_exc_ades},  {31'd0, e.exc_ades});
      chk("M_ALUResult", m_alu_result,         e.alu_result);
      chk("M_StoreData", m_store_data,         e.store_data);
      chk("M_RtRd",      {27'd0, m_rt_rd},     {27'd0, e.rt_rd});
      chk("M_RestartPC", m_restart_pc,         e.restart_pc);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    ex_stall = 1'b0; ex_flush = 1'b0; alu_stall = 1'b0; m_stall = 1'b0; m_flush = 1'b0;
    set_ex(32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    step_zero();
    reset = 1'b0;

    // ADD, MOVN/MOVZ gating, overflow suppression
    set_ex(32'h0000_0010, 32'hAAAA_0001, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h400);
    step(1, 1, 0, 0, 0, 0, 0, 32'h10, 32'hAAAA_0001, 5'd5, 32'h400);
    set_ex(32'h22, 32'h0, 5'd6, 1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h404);
    step(1, 0, 0, 0, 0, 0, 0, 32'h22, 32'h0, 5'd6, 32'h404);
    set_ex(32'h33, 32'h0, 5'd7, 1, 0, 1, 1, 0, 0, 0, 0, 0, 32'h408);
    step(1, 1, 0, 0, 0, 0, 0, 32'h33, 32'h0, 5'd7, 32'h408);
    set_ex(32'h44, 32'h0, 5'd8, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h40C);
    step(1, 1, 0, 0, 0, 0, 0, 32'h44, 32'h0, 5'd8, 32'h40C);
    set_ex(32'h55, 32'h0, 5'd9, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h410);
    step(1, 0, 0, 0, 0, 0, 0, 32'h55, 32'h0, 5'd9, 32'h410);
    set_ex(32'h7FFF_FFFF, 32'h0, 5'd10, 1, 0, 0, 0, 1, 0, 0, 0, 0, 32'h414);
    step(1, 0, 0, 0, 1, 0, 0, 32'h7FFF_FFFF, 32'h0, 5'd10, 32'h414);

    // alignment: LW misaligned, SH misaligned, SB never faults, aligned LH/LW, SW misaligned
    set_ex(32'h1002, 32'h0, 5'd11, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h418);
    step(1, 1, 0, 0, 0, 1, 0, 32'h1002, 32'h0, 5'd11, 32'h418);
    set_ex(32'h1001, 32'h0000_BEEF, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h41C);
    step(1, 0, 0, 0, 0, 0, 1, 32'h1001, 32'h0000_BEEF, 5'd0, 32'h41C);
    set_ex(32'h1003, 32'h0000_005A, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h420);
    step(1, 0, 0, 1, 0, 0, 0, 32'h1003, 32'h0000_005A, 5'd0, 32'h420);
    set_ex(32'h1002, 32'h0, 5'd12, 1, 0, 0, 0, 0, 1, 0, 0, 1, 32'h424);
    step(1, 1, 1, 0, 0, 0, 0, 32'h1002, 32'h0, 5'd12, 32'h424);
    set_ex(32'h1004, 32'h0, 5'd13, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h428);
    step(1, 1, 1, 0, 0, 0, 0, 32'h1004, 32'h0, 5'd13, 32'h428);
    set_ex(32'h2003, 32'h0000_1234, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h42C);
    step(1, 0, 0, 0, 0, 0, 1, 32'h2003, 32'h0000_1234, 5'd0, 32'h42C);

    // divider stall for three cycles with SW presented, then capture
    set_ex(32'h2000, 32'hCAFE_F00D, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h430);
    alu_stall = 1'b1;
    for (int i = 0; i < 3; i++) step_zero();
    alu_stall = 1'b0;
    step(1, 0, 0, 1, 0, 0, 0, 32'h2000, 32'hCAFE_F00D, 5'd0, 32'h430);

    // M stall holds while EX inputs change; flush under stall clears
    m_stall = 1'b1;
    set_ex(32'h99, 32'h0, 5'd14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h434);
    for (int i = 0; i < 2; i++)
      step(1, 0, 0, 1, 0, 0, 0, 32'h2000, 32'hCAFE_F00D, 5'd0, 32'h430);
    m_flush = 1'b1;
    step_zero();
    m_flush = 1'b0;
    m_stall = 1'b0;
    step(1, 1, 0, 0, 0, 0, 0, 32'h99, 32'h0, 5'd14, 32'h434);

    // EX flush under M stall holds; ALU stall with EX flush bubbles
    ex_flush = 1'b1;
    m_stall  = 1'b1;
    set_ex(32'h3000, 32'h0000_0077, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h438);
    step(1, 1, 0, 0, 0, 0, 0, 32'h99, 32'h0, 5'd14, 32'h434);
    m_stall   = 1'b0;
    alu_stall = 1'b1;
    step_zero();
    ex_flush  = 1'b0;
    alu_stall = 1'b0;
    step(1, 0, 0, 1, 0, 0, 0, 32'h3000, 32'h0000_0077, 5'd0, 32'h438);
    ex_stall = 1'b1;
    step_zero();
    ex_stall = 1'b0;
    set_ex(32'h3004, 32'h0, 5'd15, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h43C);
    step(1, 1, 1, 0, 0, 0, 0, 32'h3004, 32'h0, 5'd15, 32'h43C);

    // reset while M is stalled with valid contents
    m_stall = 1'b1;
    reset   = 1'b1;
    step_zero();
    reset   = 1'b0;
    m_stall = 1'b0;
    set_ex(32'h4000, 32'h0000_0ABC, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h440);
    step(1, 0, 0, 1, 0, 0, 0, 32'h4000, 32'h0000_0ABC, 5'd0, 32'h440);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clock);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
